// File: rtl/mdu_unit.sv
// Multiply/divide unit: multi-cycle mult/div into HI/LO with a busy window,
// plus single-cycle mul and HI/LO moves for the E stage.
module mdu_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  sel,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        req,
    output logic        start,
    output logic        busy,
    output logic [31:0] out
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    logic [8:0]    op_hit;
    logic          is_mult;
    logic          is_div;
    logic          idle_ok;

    logic [31:0]   hi_reg, hi_next;
    logic [31:0]   lo_reg, lo_next;
    logic [31:0]   pend_hi_reg, pend_hi_next;
    logic [31:0]   pend_lo_reg, pend_lo_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic          busy_reg, busy_next;

    logic [63:0]   mult_a, mult_b, prod;
    logic [31:0]   mul_lo;
    logic          a_neg, b_neg;
    logic [31:0]   a_mag, b_mag, divisor, q_mag, r_mag, quot, rem;

    genvar gi;
    generate
        for (gi = 0; gi < 9; gi++) begin : g_dec
            assign op_hit[gi] = (sel == 4'(gi));
        end
    endgenerate

    assign is_mult = op_hit[0] | op_hit[1];
    assign is_div  = op_hit[2] | op_hit[3];
    assign idle_ok = !busy_reg && !req;
    assign start   = (is_mult | is_div) && idle_ok;
    assign busy    = busy_reg;

    // Sign-extending to 64 bits lets one unsigned multiplier serve mult and multu.
    assign mult_a = {{32{op_hit[0] & A[31]}}, A};
    assign mult_b = {{32{op_hit[0] & B[31]}}, B};
    assign prod   = mult_a * mult_b;
    assign mul_lo = A * B;

    // Signed divide via magnitudes; 0x80000000 / -1 falls out as 0x80000000 rem 0.
    assign a_neg   = op_hit[2] & A[31];
    assign b_neg   = op_hit[2] & B[31];
    assign a_mag   = a_neg ? (~A + 32'd1) : A;
    assign b_mag   = b_neg ? (~B + 32'd1) : B;
    assign divisor = (b_mag == 32'd0) ? 32'd1 : b_mag;
    assign q_mag   = a_mag / divisor;
    assign r_mag   = a_mag % divisor;
    assign quot    = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
    assign rem     = a_neg ? (~r_mag + 32'd1) : r_mag;

    always_comb begin
        hi_next      = hi_reg;
        lo_next      = lo_reg;
        pend_hi_next = pend_hi_reg;
        pend_lo_next = pend_lo_reg;
        cnt_next     = cnt_reg;

        if (cnt_reg != '0) begin
            cnt_next = cnt_reg - CW'(1);
            if (cnt_reg == CW'(1)) begin
                hi_next = pend_hi_reg;
                lo_next = pend_lo_reg;
            end
        end

        if (start) begin
            if (is_mult) begin
                {pend_hi_next, pend_lo_next} = prod;
                cnt_next = CW'(MULT_CYCLES);
            end else begin
                cnt_next = CW'(DIV_CYCLES);
                // HI/LO cannot move while busy, so re-committing them leaves them intact.
                if (B == 32'd0) begin
                    pend_hi_next = hi_reg;
                    pend_lo_next = lo_reg;
                end else begin
                    pend_hi_next = rem;
                    pend_lo_next = quot;
                end
            end
        end else if (idle_ok) begin
            if (op_hit[6]) hi_next = A;
            if (op_hit[7]) lo_next = A;
        end

        busy_next = (cnt_next != '0);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hi_reg      <= '0;
            lo_reg      <= '0;
            pend_hi_reg <= '0;
            pend_lo_reg <= '0;
            cnt_reg     <= '0;
            busy_reg    <= 1'b0;
        end else begin
            hi_reg      <= hi_next;
            lo_reg      <= lo_next;
            pend_hi_reg <= pend_hi_next;
            pend_lo_reg <= pend_lo_next;
            cnt_reg     <= cnt_next;
            busy_reg    <= busy_next;
        end
    end

    always_comb begin
        out = '0;
        if (op_hit[4])      out = hi_reg;
        else if (op_hit[5]) out = lo_reg;
        else if (op_hit[8]) out = mul_lo;
    end

endmodule
